// File: rtl/unidade_busca_pkg.sv
// Shared Redux-V definitions: default datapath widths, the halt encoding and
// the fetch FSM state encoding.
package pacote_reduxv;

  localparam int         LARGURA_END   = 8;
  localparam int         LARGURA_INSTR = 8;
  localparam logic [7:0] INSTR_HALT    = 8'hFF;

  typedef enum logic {
    BUSCA  = 1'b0,
    PARADO = 1'b1
  } estado_t;

endpackage

// File: rtl/unidade_busca.sv
// Redux-V fetch stage: owns the PC, addresses the combinational instruction
// memory and holds one fetched instruction behind a valid/ready handshake.
//
// state  | meaning
// BUSCA  | fetching one instruction per free output slot
// PARADO | halt instruction captured; fetch frozen until desvio or reset
module unidade_busca #(
  parameter int                       LARGURA_END   = pacote_reduxv::LARGURA_END,
  parameter int                       LARGURA_INSTR = pacote_reduxv::LARGURA_INSTR,
  parameter logic [LARGURA_END-1:0]   PC_INICIAL    = '0,
  parameter logic [LARGURA_INSTR-1:0] INSTR_HALT    = LARGURA_INSTR'(pacote_reduxv::INSTR_HALT),
  parameter bit                       HALT_ATIVO    = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     habilita,
  input  logic                     desvio,
  input  logic [LARGURA_END-1:0]   alvo,
  output logic [LARGURA_END-1:0]   endereco,
  input  logic [LARGURA_INSTR-1:0] instrucao,
  output logic [LARGURA_INSTR-1:0] instr_saida,
  output logic [LARGURA_END-1:0]   pc_saida,
  output logic                     valido,
  input  logic                     pronto,
  output logic                     parado
);

  import pacote_reduxv::*;

  estado_t                  r_estado;
  logic [LARGURA_END-1:0]   r_pc;
  logic [LARGURA_INSTR-1:0] r_instr;
  logic [LARGURA_END-1:0]   r_pc_saida;
  logic                     r_valido;
  logic                     r_parado;

  logic w_livre;
  logic w_eh_halt;
  logic w_consumido;

  assign endereco    = r_pc;
  assign instr_saida = r_instr;
  assign pc_saida    = r_pc_saida;
  assign valido      = r_valido;
  assign parado      = r_parado;

  assign w_livre     = !r_valido || pronto;
  assign w_consumido = r_valido && pronto;
  // The halt compare is the only path from instrucao into the control state.
  assign w_eh_halt   = HALT_ATIVO && (instrucao == INSTR_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado   <= BUSCA;
      r_pc       <= PC_INICIAL;
      r_instr    <= '0;
      r_pc_saida <= '0;
      r_valido   <= 1'b0;
      r_parado   <= 1'b0;
    end else begin
      case (r_estado)
        BUSCA: begin
          if (desvio) begin
            r_pc     <= alvo;
            r_valido <= 1'b0;
          end else if (habilita && w_livre) begin
            r_instr    <= instrucao;
            r_pc_saida <= r_pc;
            r_valido   <= 1'b1;
            if (w_eh_halt) begin
              r_estado <= PARADO;
              r_parado <= 1'b1;
            end else begin
              r_pc <= r_pc + LARGURA_END'(1);
            end
          end else if (w_consumido) begin
            r_valido <= 1'b0;
          end
        end
        PARADO: begin
          if (desvio) begin
            r_pc     <= alvo;
            r_valido <= 1'b0;
            r_estado <= BUSCA;
            r_parado <= 1'b0;
          end else if (w_consumido) begin
            r_valido <= 1'b0;
          end
        end
        default: begin
          r_estado <= BUSCA;
          r_parado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_busca.sv
// Directed bench for unidade_busca with a behavioural combinational
// instruction memory (mem[i] = i unless overridden).
`timescale 1ns/1ps
module tb_unidade_busca;

  logic       clk;
  logic       rst_n;
  logic       habilita;
  logic       desvio;
  logic [7:0] alvo;
  logic [7:0] endereco;
  logic [7:0] instrucao;
  logic [7:0] instr_saida;
  logic [7:0] pc_saida;
  logic       valido;
  logic       pronto;
  logic       parado;

  logic [7:0] mem [256];

  int n_vec = 0;
  int n_err = 0;

  unidade_busca dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .habilita    (habilita),
    .desvio      (desvio),
    .alvo        (alvo),
    .endereco    (endereco),
    .instrucao   (instrucao),
    .instr_saida (instr_saida),
    .pc_saida    (pc_saida),
    .valido      (valido),
    .pronto      (pronto),
    .parado      (parado)
  );

  assign instrucao = mem[endereco];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] pcs,
                         input logic [7:0] ins, input logic [7:0] ende, input logic par);
    chk({tag, ".valido"}, valido, v);
    if (v) begin
      chk({tag, ".pc_saida"}, pc_saida, pcs);
      chk({tag, ".instr_saida"}, instr_saida, ins);
    end
    chk({tag, ".endereco"}, endereco, ende);
    chk({tag, ".parado"}, parado, par);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[255] = 8'hAA;   // keep the wrap test clear of the halt encoding

    rst_n = 1'b0; habilita = 1'b1; pronto = 1'b1; desvio = 1'b0; alvo = 8'h00;
    #2;
    chk("rst.valido", valido, 0);
    chk("rst.endereco", endereco, 0);
    chk("rst.pc_saida", pc_saida, 0);
    chk("rst.instr_saida", instr_saida, 0);
    chk("rst.parado", parado, 0);
    #1 rst_n = 1'b1;

    // Streaming: one instruction per cycle, pc_saida 0..5
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out($sformatf("seq%0d", i), 1'b1, 8'(i), 8'(i), 8'(i + 1), 1'b0);
    end

    // Stall at pc_saida=5 for three cycles
    pronto = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("stall%0d", i), 1'b1, 8'd5, 8'd5, 8'd6, 1'b0);
    end
    pronto = 1'b1;
    for (int i = 6; i < 10; i++) begin
      tick();
      chk_out($sformatf("resume%0d", i), 1'b1, 8'(i), 8'(i), 8'(i + 1), 1'b0);
    end

    // Redirect at pc=10 to 100: one bubble
    desvio = 1'b1; alvo = 8'd100;
    tick();
    chk_out("desvio.bolha", 1'b0, 8'd0, 8'd0, 8'd100, 1'b0);
    desvio = 1'b0;
    tick();
    chk_out("desvio.alvo", 1'b1, 8'd100, 8'd100, 8'd101, 1'b0);

    // Redirect during a stall still flushes
    pronto = 1'b0; desvio = 1'b1; alvo = 8'd20;
    tick();
    chk_out("desvio_stall.bolha", 1'b0, 8'd0, 8'd0, 8'd20, 1'b0);
    desvio = 1'b0;
    tick();
    chk_out("desvio_stall.alvo", 1'b1, 8'd20, 8'd20, 8'd21, 1'b0);
    pronto = 1'b1;

    // Fetch disabled: drain then hold
    habilita = 1'b0;
    tick();
    chk_out("hab0.drain", 1'b0, 8'd0, 8'd0, 8'd21, 1'b0);
    tick();
    chk_out("hab0.hold", 1'b0, 8'd0, 8'd0, 8'd21, 1'b0);

    // Redirect with habilita=0, then wrap 254,255,0,1
    desvio = 1'b1; alvo = 8'd254;
    tick();
    chk_out("wrap.bolha", 1'b0, 8'd0, 8'd0, 8'd254, 1'b0);
    desvio = 1'b0; habilita = 1'b1;
    tick();
    chk_out("wrap.254", 1'b1, 8'd254, 8'd254, 8'd255, 1'b0);
    tick();
    chk_out("wrap.255", 1'b1, 8'd255, 8'hAA, 8'd0, 1'b0);
    tick();
    chk_out("wrap.0", 1'b1, 8'd0, 8'd0, 8'd1, 1'b0);
    tick();
    chk_out("wrap.1", 1'b1, 8'd1, 8'd1, 8'd2, 1'b0);

    // Halt on mem[3]=FF
    mem[3] = 8'hFF;
    desvio = 1'b1; alvo = 8'd0;
    tick();
    chk_out("halt.bolha", 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    desvio = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("halt.seq%0d", i), 1'b1, 8'(i), 8'(i), 8'(i + 1), 1'b0);
    end
    tick();
    chk_out("halt.captura", 1'b1, 8'd3, 8'hFF, 8'd3, 1'b1);
    pronto = 1'b0;
    tick();
    chk_out("halt.espera", 1'b1, 8'd3, 8'hFF, 8'd3, 1'b1);
    pronto = 1'b1;
    tick();
    chk_out("halt.consumido", 1'b0, 8'd0, 8'd0, 8'd3, 1'b1);
    tick();
    chk_out("halt.congelado", 1'b0, 8'd0, 8'd0, 8'd3, 1'b1);
    desvio = 1'b1; alvo = 8'd0;
    tick();
    chk_out("halt.saida", 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    desvio = 1'b0;
    tick();
    chk_out("halt.retoma", 1'b1, 8'd0, 8'd0, 8'd1, 1'b0);

    // Async reset asserted between edges during a stall
    pronto = 1'b0;
    tick();
    chk_out("areset.stall", 1'b1, 8'd0, 8'd0, 8'd1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("areset.valido", valido, 0);
    chk("areset.endereco", endereco, 0);
    chk("areset.pc_saida", pc_saida, 0);
    #2 rst_n = 1'b1;
    tick();
    chk_out("areset.refetch", 1'b1, 8'd0, 8'd0, 8'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/unidade_busca.md
Name: unidade_busca

Overview:
- Fetch stage of the Redux-V core; sits directly upstream of memoria_instrucoes.
- Owns the program counter and drives the memory's `endereco`; the memory's read is combinational.
- Captures the returned `instrucao` into a fetch output register that presents a valid/ready handshake to decode.
- Supports branch redirect with flush, an external fetch enable, and a halt state entered on a configurable halt instruction.

Parameters:
- LARGURA_END, 8, PC / address width.
- LARGURA_INSTR, 8, instruction width.
- PC_INICIAL, 0, PC value after reset.
- INSTR_HALT, 8'hFF, instruction encoding that halts fetch.
- HALT_ATIVO, 1, 1 = halt detection enabled, 0 = INSTR_HALT ignored.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- habilita  in  1  fetch enable; 0 = issue no new fetches.
- desvio  in  1  redirect request, single-cycle strobe from execute.
- alvo  in  LARGURA_END  redirect target, sampled when desvio=1.
- endereco  out  LARGURA_END  address to memoria_instrucoes; equals the pc register.
- instrucao  in  LARGURA_INSTR  data from memoria_instrucoes, valid in the same cycle.
- instr_saida  out  LARGURA_INSTR  registered instruction to decode.
- pc_saida  out  LARGURA_END  address of instr_saida.
- valido  out  1  instr_saida/pc_saida hold a live instruction.
- pronto  in  1  decode accepts this cycle; a transfer occurs when valido & pronto.
- parado  out  1  1 while in state PARADO.

Behaviour:
- Reset (rst_n=0, async):
  - pc=PC_INICIAL, instr_saida=0, pc_saida=0, valido=0, parado=0, state=BUSCA.
  - Release is synchronous to clk: first fetch is captured on the first rising edge with rst_n=1.
- endereco = pc, purely combinational; no other logic on this path.
- Define `livre` = !valido | pronto (the output slot is free or is being consumed).
- State BUSCA, evaluated per rising edge in priority order:
  1. desvio=1 → pc<=alvo, valido<=0 (flush; the in-flight instruction is dropped even if pronto=1), stay in BUSCA.
  2. habilita=1 & livre → instr_saida<=instrucao, pc_saida<=pc, valido<=1, pc<=pc+1.
     - If HALT_ATIVO & instrucao==INSTR_HALT: pc holds (no increment) and next state is PARADO.
  3. habilita=0 & valido & pronto → valido<=0; pc holds.
  4. Otherwise (stall: valido & !pronto) → all registers hold; instr_saida and pc_saida remain stable.
- State PARADO:
  - parado=1. The halt instruction stays in the output register until consumed (valido & pronto → valido<=0).
  - No fetch; pc frozen.
  - desvio=1 → pc<=alvo, valido<=0, state<=BUSCA, parado<=0.
  - Only reset or desvio leave PARADO.
- Throughput and latency:
  - One instruction per cycle while pronto=1 and habilita=1.
  - Latency from pc to valido is 1 cycle.
  - Redirect costs exactly 1 bubble cycle: valido=0 in the cycle after desvio.
- Arithmetic: pc+1 is modulo 2^LARGURA_END; 8'd255 wraps to 8'd0 with no flag.
- Simultaneous events: desvio with habilita=0 still redirects; desvio during stall still flushes.
- Reset mid-operation: everything returns to reset values immediately, independent of clk.
- No X propagation: valido never depends on instrucao except through the halt compare.

Decomposition:
- Shared package (pacote_reduxv): LARGURA_END, LARGURA_INSTR, INSTR_HALT default, and the state encoding (BUSCA=1'b0, PARADO=1'b1).
- No sub-module. The PC register, output register and FSM fit in one module.
- memoria_instrucoes is instantiated alongside this block at the core level, not inside it.

Test Plan:
- Reset then pronto=1, habilita=1, memory preloaded mem[i]=i: endereco 0,1,2… each cycle; valido=1 from cycle 1; pc_saida/instr_saida = 0,1,2….
- Stall: pronto=0 for 3 cycles at pc_saida=5 → instr_saida/pc_saida hold 5, endereco holds 6. pronto=1 → next output is pc_saida=6.
- Redirect: desvio=1, alvo=8'd100 at pc=10 → next cycle valido=0, endereco=100; following cycle pc_saida=100, instr_saida=mem[100].
- Wrap: jump to alvo=8'd254 → pc_saida sequence 254, 255, 0, 1.
- Halt: mem[3]=8'hFF → pc_saida=3 output with valido=1, parado=1, endereco stays 3. After consumption valido=0. desvio alvo=0 → parado=0 and fetch resumes at 0.
- Async reset asserted mid-stall between clock edges → valido=0 and endereco=0 immediately, without waiting for a clk edge.
